mem_bus_ctrl: RTL and testbench

CPU-side bus controller that sits directly upstream of the internal RAM. It turns single-cycle CPU read/write requests (byte or 16-bit word) into correctly sequenced RAM strobe cycles: `cs_`, `oe_`, `we_`, address and bidirectional 8-bit data. It inserts programmable wait states, splits word accesses into two little-endian byte cycles, and flags accesses outside the RAM window.

---
 rtl/mem_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-side controller sitting directly in front of the internal RAM.
// Turns single-cycle CPU byte/word requests into sequenced RAM strobe cycles.
// It inserts WaitStates extra strobe cycles per byte and splits 16-bit words into
// two little-endian byte cycles. It also flags bytes that fall outside the RAM window.
//
// Parameters
//   WaitStates : extra strobe cycles per byte (strobe lasts 1+WaitStates cycles)
//   RamBase    : first byte address decoded to the RAM
//   RamSize    : RAM window size in bytes
//
// Ports
//   clk, rst_               : clock, asynchronous active-low reset
//   req, wr, word           : CPU request, write/read select, word/byte select
//   addr, wdata             : CPU byte address and write data (latched at accept)
//   rdata, ack, err, busy   : read result, completion pulse, window error, busy flag
//   mem_cs_, mem_oe_, mem_we_ : RAM strobes, active-low, all registered
//   mem_addr                : RAM byte address, registered
//   mem_data                : bidirectional RAM data bus
//
// The FSM (stage p0) decides what the bus should do. Every RAM-facing signal and
// ack/err is then registered once (stage p1), so the RAM sees the sequence one cycle
// after the FSM state that produced it. There is no combinational path from the CPU to the RAM.
module mem_bus_ctrl #(
  parameter int unsigned WaitStates = 1,
  parameter logic [15:0] RamBase    = 16'h0000,
  parameter int unsigned RamSize    = 256
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req,
  input  logic        wr,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic        mem_cs_,
  output logic        mem_oe_,
  output logic        mem_we_,
  output logic [15:0] mem_addr,
  inout  wire  [7:0]  mem_data
);

  localparam int CntW = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  // Window decode is done on the offset from RamBase, modulo 2^16.
  // This lets a window that starts near the top of the map continue across the wrap to 16'h0000.
  function automatic logic in_window(input logic [15:0] a);
    logic [15:0] off;
    off = a - RamBase;
    return (32'(off) < RamSize);
  endfunction

  // ---- stage p0: request latch and sequencing FSM ----
  state_t            state, state_nx;
  logic [CntW-1:0]   cnt, cnt_nx;
  logic              idx, idx_nx;
  logic              err_flag, err_flag_nx;
  logic              wr_p0, word_p0;
  logic [15:0]       addr_p0, wdata_p0;

  logic [15:0]       cur_addr;
  logic [7:0]        cur_byte;
  logic              hit;

  logic              cs_nx, oe_nx, we_nx, drv_nx, cap_nx, ack_nx, err_nx;
  logic [15:0]       maddr_nx;

  // ---- stage p1: registered bus side ----
  logic              drv_p1, cap_p1, cap_idx_p1;
  logic [7:0]        wbyte_p1;
  logic [7:0]        rbyte0, rbyte1;

  assign cur_addr = addr_p0 + {15'd0, idx};
  assign cur_byte = idx ? wdata_p0[15:8] : wdata_p0[7:0];
  assign hit      = in_window(cur_addr);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    err_flag_nx = err_flag;
    cs_nx       = 1'b1;
    oe_nx       = 1'b1;
    we_nx       = 1'b1;
    drv_nx      = 1'b0;
    cap_nx      = 1'b0;
    ack_nx      = 1'b0;
    err_nx      = 1'b0;
    maddr_nx    = mem_addr;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx    = SETUP;
          idx_nx      = 1'b0;
          err_flag_nx = 1'b0;
        end
      end
      SETUP: begin
        maddr_nx = cur_addr;
        drv_nx   = wr_p0;
        cnt_nx   = CntW'(WaitStates);
        state_nx = STROBE;
      end
      STROBE: begin
        maddr_nx = cur_addr;
        drv_nx   = wr_p0;
        cs_nx    = ~hit;
        oe_nx    = ~(hit & ~wr_p0);
        we_nx    = ~(hit & wr_p0);
        if (!hit) err_flag_nx = 1'b1;
        if (cnt == '0) begin
          // Last strobe cycle of this byte: reads latch the bus one cycle later in p1.
          cap_nx = ~wr_p0;
          if (word_p0 && !idx) begin
            idx_nx   = 1'b1;
            state_nx = SETUP;
          end else begin
            state_nx = ACK;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ACK: begin
        ack_nx   = 1'b1;
        err_nx   = err_flag;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= 1'b0;
      err_flag <= 1'b0;
      wr_p0    <= 1'b0;
      word_p0  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      err_flag <= err_flag_nx;
      if (state == IDLE && req) begin
        wr_p0   <= wr;
        word_p0 <= word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
    wbyte_p1 <= cur_byte;
  end

  // ---- stage p1: registered strobes, address, completion and read capture ----
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_cs_    <= 1'b1;
      mem_oe_    <= 1'b1;
      mem_we_    <= 1'b1;
      mem_addr   <= 16'h0000;
      drv_p1     <= 1'b0;
      cap_p1     <= 1'b0;
      cap_idx_p1 <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rbyte0     <= 8'h00;
      rbyte1     <= 8'h00;
    end else begin
      mem_cs_    <= cs_nx;
      mem_oe_    <= oe_nx;
      mem_we_    <= we_nx;
      mem_addr   <= maddr_nx;
      drv_p1     <= drv_nx;
      cap_p1     <= cap_nx;
      cap_idx_p1 <= idx;
      ack        <= ack_nx;
      err        <= err_nx;
      // A miss never asserted chip select, so the byte reads back as 8'hFF.
      if (cap_p1) begin
        if (cap_idx_p1) rbyte1 <= mem_cs_ ? 8'hFF : mem_data;
        else            rbyte0 <= mem_cs_ ? 8'hFF : mem_data;
      end
    end
  end

  // Drive only during write SETUP/STROBE; output enable is only ever low for reads.
  assign mem_data = drv_p1 ? wbyte_p1 : 8'hzz;
  assign rdata    = word_p0 ? {rbyte1, rbyte0} : {8'h00, rbyte0};
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_, req, wr, word, sel, probe;
  logic [15:0] addr, wdata;
  logic        req1, req2;
  assign req1 = req & ~sel;
  assign req2 = req & sel;

  logic [15:0] rdata1, rdata2, maddr1, maddr2;
  logic        ack1, err1, busy1, cs1, oe1, we1;
  logic        ack2, err2, busy2, cs2, oe2, we2;
  wire  [7:0]  md1, md2;

  logic [7:0] ram1 [0:65535];
  logic [7:0] ram2 [0:65535];

  mem_bus_ctrl #(.WaitStates(1), .RamBase(16'h0000), .RamSize(256)) dut1 (
    .clk(clk), .rst_(rst_), .req(req1), .wr(wr), .word(word), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1),
    .mem_cs_(cs1), .mem_oe_(oe1), .mem_we_(we1), .mem_addr(maddr1), .mem_data(md1));

  mem_bus_ctrl #(.WaitStates(0), .RamBase(16'hFF00), .RamSize(512)) dut2 (
    .clk(clk), .rst_(rst_), .req(req2), .wr(wr), .word(word), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2),
    .mem_cs_(cs2), .mem_oe_(oe2), .mem_we_(we2), .mem_addr(maddr2), .mem_data(md2));

  // RAM models: drive on chip select + output enable, write on every edge with we low.
  assign md1 = (!cs1 && !oe1) ? ram1[maddr1] : 8'hzz;
  assign md2 = (!cs2 && !oe2) ? ram2[maddr2] : 8'hzz;
  // Probe driver: a known value placed on an otherwise idle bus reveals any other driver.
  assign md1 = (probe && !sel) ? 8'h5A : 8'hzz;

  always @(posedge clk) begin
    if (!cs1 && !we1) ram1[maddr1] <= md1;
    if (!cs2 && !we2) ram2[maddr2] <= md2;
  end

  int busbad = 0;
  always @(negedge clk) begin
    if ((!cs1 && !oe1 && md1 !== ram1[maddr1]) || (!cs2 && !oe2 && md2 !== ram2[maddr2]))
      busbad <= busbad + 1;
  end

  logic        ack_m, err_m, busy_m, cs_m, we_m;
  logic [15:0] rdata_m;
  assign ack_m   = sel ? ack2 : ack1;
  assign err_m   = sel ? err2 : err1;
  assign busy_m  = sel ? busy2 : busy1;
  assign cs_m    = sel ? cs2 : cs1;
  assign we_m    = sel ? we2 : we1;
  assign rdata_m = sel ? rdata2 : rdata1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; returns read data, err, edges from accept to ack, and strobe cycle counts.
  task automatic access(input logic s, input logic w, input logic wd, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rd, output logic e,
                        output int lat, output int we_n, output int cs_n);
    sel = s; wr = w; word = wd; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("busy_after_accept", busy_m, 1'b1);
    lat = 0; we_n = 0; cs_n = 0;
    while (lat < 40) begin
      if (!we_m) we_n++;
      if (!cs_m) cs_n++;
      @(posedge clk); #1;
      lat++;
      if (ack_m) break;
    end
    rd = rdata_m;
    e  = err_m;
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat, wn, cn, n, nack, last;

  initial begin
    rst_ = 1'b0; req = 1'b0; wr = 1'b0; word = 1'b0; sel = 1'b0; probe = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", cs1, 1'b1);
    chk("rst_oe", oe1, 1'b1);
    chk("rst_we", we1, 1'b1);
    chk("rst_addr", maddr1, 16'h0000);
    chk("rst_ack", ack1, 1'b0);
    chk("rst_err", err1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_rdata", rdata1, 16'h0000);
    probe = 1'b1; #1;
    chk("rst_bus_released", md1, 8'h5A);
    probe = 1'b0;
    #2 rst_ = 1'b1;
    @(posedge clk); #1;

    // Byte write then read, one wait state.
    access(1'b0, 1'b1, 1'b0, 16'h0002, 16'h00AA, rd, e, lat, wn, cn);
    chk("bw_latency", lat, 4);
    chk("bw_err", e, 1'b0);
    chk("bw_we_cycles", wn, 2);
    chk("bw_ram", ram1[2], 8'hAA);
    access(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, rd, e, lat, wn, cn);
    chk("br_rdata", rd, 16'h00AA);
    chk("br_latency", lat, 4);

    // Word write, little-endian byte reads, word read.
    access(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1255, rd, e, lat, wn, cn);
    chk("ww_latency", lat, 7);
    chk("ww_err", e, 1'b0);
    chk("ww_we_cycles", wn, 4);
    chk("ww_ram_lo", ram1[16'h0010], 8'h55);
    chk("ww_ram_hi", ram1[16'h0011], 8'h12);
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, e, lat, wn, cn);
    chk("br_lo", rd, 16'h0055);
    access(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, rd, e, lat, wn, cn);
    chk("br_hi", rd, 16'h0012);
    access(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, rd, e, lat, wn, cn);
    chk("wr_rdata", rd, 16'h1255);
    chk("wr_latency", lat, 7);

    // Out of window byte read.
    access(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, rd, e, lat, wn, cn);
    chk("oow_rdata", rd, 16'h00FF);
    chk("oow_err", e, 1'b1);
    chk("oow_cs_cycles", cn, 0);

    // Word straddling the top of the window: low byte hits, high byte misses.
    access(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0034, rd, e, lat, wn, cn);
    access(1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0000, rd, e, lat, wn, cn);
    chk("half_rdata", rd, 16'hFF34);
    chk("half_err", e, 1'b1);

    // req held high: accepts only after ack, ack every 4+1 edges.
    sel = 1'b0; wr = 1'b0; word = 1'b0; addr = 16'h0002; req = 1'b1;
    n = 0; nack = 0; last = 0;
    while (nack < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (ack1) begin
        chk("hold_rdata", rdata1, 16'h00AA);
        if (nack > 0) chk("hold_gap", n - last, 5);
        last = n;
        nack++;
      end
    end
    req = 1'b0;
    chk("hold_acks", nack, 3);
    @(posedge clk); #1;
    chk("hold_idle", busy1, 1'b0);

    // Reset in the middle of a word write strobe.
    sel = 1'b0; wr = 1'b1; word = 1'b1; addr = 16'h0020; wdata = 16'hBEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (we1 !== 1'b0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reach_strobe", we1, 1'b0);
    #2 rst_ = 1'b0;
    #1;
    chk("mid_we", we1, 1'b1);
    chk("mid_cs", cs1, 1'b1);
    chk("mid_busy", busy1, 1'b0);
    chk("mid_addr", maddr1, 16'h0000);
    probe = 1'b1; #1;
    chk("mid_bus_released", md1, 8'h5A);
    probe = 1'b0;
    #2 rst_ = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, rd, e, lat, wn, cn);
    chk("post_rst_rdata", rd, 16'h00AA);
    chk("post_rst_latency", lat, 4);

    // Zero wait states, window at 16'hFF00 spanning the address wrap.
    access(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hABCD, rd, e, lat, wn, cn);
    chk("wrap_ww_latency", lat, 5);
    chk("wrap_ww_err", e, 1'b0);
    chk("wrap_ww_we_cycles", wn, 2);
    chk("wrap_ram_lo", ram2[16'hFFFF], 8'hCD);
    chk("wrap_ram_hi", ram2[16'h0000], 8'hAB);
    access(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, rd, e, lat, wn, cn);
    chk("wrap_wr_rdata", rd, 16'hABCD);
    chk("wrap_wr_err", e, 1'b0);
    access(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, rd, e, lat, wn, cn);
    chk("ws0_oow_rdata", rd, 16'h00FF);
    chk("ws0_oow_err", e, 1'b1);
    chk("ws0_oow_latency", lat, 3);
    chk("ws0_oow_cs_cycles", cn, 0);

    @(posedge clk); #1;
    chk("bus_contention", busbad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
